uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter that consumes the byte stream produced by the chunk serializer and drives it off-chip on a single TX pin. Accepts one byte per AXI-Stream handshake, frames it as start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits, and exerts backpressure until the frame is on the line. It is the last stage of the image output path.

## Interface

Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz.
- BAUD, 115_200: line rate in bits/s. CLKS_PER_BIT = CLK_FREQ / BAUD (integer division, truncating). Elaboration fails if CLKS_PER_BIT < 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2. Any other value fails elaboration.

Ports:
- clk, input, 1: single clock; all logic is on its rising edge.
- rst, input, 1: synchronous, active-low reset. rst = 0 resets the block; rst = 1 is normal operation.
- axis_i, axis_if slave, DATA_TYPE logic [7:0]: byte input. Uses data, vld and rdy.
- tx, output, 1: serial line. Idle level is 1.
- busy, output, 1: high from the handshake cycle until the last stop bit completes.

## Operation

- Registered FSM with states IDLE, START, DATA, PARITY, STOP.
- A bit-period counter runs 0..CLKS_PER_BIT-1 and a bit index runs 0..7 for data and 0..STOP_BITS-1 for stop bits.
- IDLE: tx = 1. A handshake (vld && rdy) latches data into the shift register and moves the FSM to START.
- START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift[0]. The register shifts right at each bit-period end. After bit 7, the FSM goes to PARITY if PARITY != 0, else to STOP.
- PARITY: tx = ^byte for even parity, or ~^byte for odd parity. Lasts one bit period, then STOP.
- STOP: tx = 1 for STOP_BITS bit periods. At the end of the last one, the FSM goes to START if a handshake occurs in that cycle, else to IDLE.
- rdy = rst && (state == IDLE || (state == STOP && last stop bit && counter == CLKS_PER_BIT-1)). This allows back-to-back frames with no idle gap.
- The latched byte is held stable for the whole frame. Changes on axis_i.data after the handshake have no effect.
- vld asserted while rdy = 0 is ignored. The upstream stage must hold data until rdy is seen.

## Timing

- Reset (rst = 0 at a rising edge): state = IDLE, counters = 0, tx = 1, busy = 0. rdy is forced to 0 combinationally while rst = 0, so no handshake is accepted during reset.
- Reset asserted mid-frame aborts the frame. tx returns to 1 on the following cycle and no partial byte is resumed.
- Handshake at edge k: tx = 0 from cycle k+1. busy = 1 from cycle k+1.
- Each bit is exactly CLKS_PER_BIT cycles. Frame length F = CLKS_PER_BIT × (1 + 8 + (PARITY != 0) + STOP_BITS) cycles.
- rdy is high for exactly one cycle, the final cycle of the last stop bit, while a frame is in flight.
- Back-to-back streaming: frame spacing is exactly F cycles, and each start bit follows the previous last stop bit immediately.
- busy deasserts one cycle after the final stop cycle if no new handshake occurs in that cycle.
- tx is driven from a flop, so it is glitch-free.

## Test plan

Use CLK_FREQ = 1_000_000 and BAUD = 100_000 (CLKS_PER_BIT = 10) unless stated otherwise.
- Single byte 0xA5, PARITY = 0, STOP_BITS = 1: tx = 0 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles. rdy stays low for 99 cycles after the handshake.
- Back-to-back stream 0x00, 0xFF, 0x55 with vld held high: handshakes occur exactly 100 cycles apart and tx shows no idle cycle between frames. A sampling UART model recovers all three bytes.
- PARITY = 1 with 0x07: parity bit = 1. PARITY = 2 with 0x07: parity bit = 0. With STOP_BITS = 2, the frame is 120 cycles.
- Backpressure: change data while vld is high and rdy is low mid-frame. Only the byte present on the rdy cycle is transmitted, and exactly once.
- Reset at cycle 35 of a frame: tx = 1 and busy = 0 on the next cycle, rdy = 0 while rst = 0. A fresh byte after release transmits correctly.
- Idle check: with vld = 0 for 500 cycles after reset, tx = 1 constantly, busy = 0 and rdy = 1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: accepts one byte per stream handshake and sends it as an asynchronous
// serial frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] axis_i_data,
    input  logic       axis_i_vld,
    output logic       axis_i_rdy,
    output logic       tx,
    output logic       busy
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ / BAUD must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shift, shift_d;
    logic [7:0]    data_q, data_d;
    logic          tx_d;
    logic          bit_end;
    logic          last_stop;
    logic          hs;
    logic          par_bit;

    assign bit_end    = (cnt == CNT_LAST);
    assign last_stop  = (state == ST_STOP) && (idx == STOP_LAST) && bit_end;
    assign axis_i_rdy = rst && ((state == ST_IDLE) || last_stop);
    assign hs         = axis_i_vld && axis_i_rdy;
    assign par_bit    = (PARITY == 2) ? ~^data_q : ^data_q;

    always_comb begin
        state_d = state;
        cnt_d   = bit_end ? '0 : cnt + 1'b1;
        idx_d   = idx;
        shift_d = shift;
        data_d  = data_q;
        case (state)
            ST_IDLE: begin
                cnt_d = '0;
                if (hs) begin
                    state_d = ST_START;
                    shift_d = axis_i_data;
                    data_d  = axis_i_data;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift[7:1]};
                    if (idx == 3'd7) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx == STOP_LAST) begin
                        idx_d = '0;
                        // a handshake on the final stop cycle chains straight into the next start bit
                        if (hs) begin
                            state_d = ST_START;
                            shift_d = axis_i_data;
                            data_d  = axis_i_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // tx is registered from the next-state view so the line changes with the state
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            data_q <= '0;
            tx     <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            idx    <= idx_d;
            shift  <= shift_d;
            data_q <= data_d;
            tx     <= tx_d;
            busy   <= (state_d != ST_IDLE);
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters (no parity/1 stop, even/2 stop, odd/1 stop) at
// 10 clocks per bit, checked cycle by cycle against a frame-level line model.
module tb_uart_tx;
    localparam int CPB = 10;

    logic       clk;
    logic       rst;
    logic [2:0] vld;
    logic [2:0] rdy;
    logic [2:0] tx;
    logic [2:0] busy;
    logic [7:0] data [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx #(
            .CLK_FREQ (1_000_000),
            .BAUD     (100_000),
            .PARITY   (g),
            .STOP_BITS((g == 1) ? 2 : 1)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .axis_i_data(data[g]),
            .axis_i_vld (vld[g]),
            .axis_i_rdy (rdy[g]),
            .tx         (tx[g]),
            .busy       (busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // dut0: no parity, 1 stop; dut1: even parity, 2 stops; dut2: odd parity, 1 stop
    function automatic int flen(input int d);
        return CPB * (1 + 8 + ((d != 0) ? 1 : 0) + ((d == 1) ? 2 : 1));
    endfunction

    function automatic logic exp_bit(input int d, input logic [7:0] b, input int slot);
        int ones;
        ones = 0;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (d != 0 && slot == 9) begin
            for (int i = 0; i < 8; i++) ones += int'(b[i]);
            return (d == 1) ? 1'(ones % 2) : 1'(1 - (ones % 2));
        end
        return 1'b1;
    endfunction

    // Streams bytes with vld held high; optionally scrambles data while rdy is low.
    task automatic send_stream(input int d, input logic [7:0] q[$], input bit wiggle);
        int f, waited, slot;
        logic ebit;
        logic [7:0] rx;
        f = flen(d);
        data[d] = q[0];
        vld[d]  = 1'b1;
        waited  = 0;
        while (rdy[d] !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (rdy[d] !== 1'b1) begin
            errors++;
            $display("FAIL stream_rdy_timeout dut%0d rdy=%b required 1", d, rdy[d]);
            vld[d] = 1'b0;
            return;
        end
        for (int i = 0; i < q.size(); i++) begin
            rx = '0;
            for (int n = 1; n <= f; n++) begin
                @(negedge clk);
                slot = (n - 1) / CPB;
                ebit = exp_bit(d, q[i], slot);
                checks++;
                if (tx[d] !== ebit) begin
                    errors++;
                    $display("FAIL frame_tx dut%0d byte%0d cycle%0d tx=%b required %b", d, i, n, tx[d], ebit);
                end
                checks++;
                if (busy[d] !== 1'b1 || rdy[d] !== 1'(n == f)) begin
                    errors++;
                    $display("FAIL frame_ctl dut%0d byte%0d cycle%0d busy=%b rdy=%b required busy=1 rdy=%b",
                             d, i, n, busy[d], rdy[d], 1'(n == f));
                end
                if ((n - 1) % CPB == CPB / 2 && slot >= 1 && slot <= 8) rx[slot-1] = tx[d];
                if (n == f) begin
                    if (i + 1 < q.size()) data[d] = q[i+1];
                    else vld[d] = 1'b0;
                end else if (wiggle) begin
                    data[d] = 8'($urandom);
                end
            end
            checks++;
            if (rx !== q[i]) begin
                errors++;
                $display("FAIL frame_decode dut%0d byte%0d got=%02h required %02h", d, i, rx, q[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy[d] !== 1'b0 || tx[d] !== 1'b1) begin
            errors++;
            $display("FAIL post_frame dut%0d busy=%b tx=%b required busy=0 tx=1", d, busy[d], tx[d]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        vld = '1;
        for (int d = 0; d < 3; d++) data[d] = 8'($urandom);
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 3'b111 || busy !== 3'b000 || rdy !== 3'b000) begin
            errors++;
            $display("FAIL reset_state tx=%b busy=%b rdy=%b required tx=111 busy=000 rdy=000", tx, busy, rdy);
        end
        vld = '0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle;
        int bad;
        bad = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            checks++;
            if (tx !== 3'b111 || busy !== 3'b000 || rdy !== 3'b111) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL idle cycle%0d tx=%b busy=%b rdy=%b required tx=111 busy=000 rdy=111",
                             c, tx, busy, rdy);
            end
        end
    endtask

    task automatic test_single;
        logic [7:0] q[$];
        q.push_back(8'hA5);
        send_stream(0, q, 1'b0);
    endtask

    task automatic test_parity;
        logic [7:0] q[$];
        q.push_back(8'h07);
        send_stream(1, q, 1'b0);
        send_stream(2, q, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [7:0] q[$];
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'h55);
        send_stream(0, q, 1'b0);
        send_stream(1, q, 1'b0);
    endtask

    task automatic test_backpressure;
        logic [7:0] q[$];
        for (int d = 0; d < 3; d++) begin
            q.delete();
            repeat (3) q.push_back(8'($urandom));
            send_stream(d, q, 1'b1);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] q[$];
        int waited;
        data[0] = 8'h3C;
        vld[0]  = 1'b1;
        waited  = 0;
        while (rdy[0] !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (n == 1) vld[0] = 1'b0;
        end
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy busy=%b required 1", busy[0]);
        end
        rst = 1'b0;
        vld = '1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (tx !== 3'b111 || busy !== 3'b000 || rdy !== 3'b000) begin
                errors++;
                $display("FAIL midframe_reset cycle%0d tx=%b busy=%b rdy=%b required tx=111 busy=000 rdy=000",
                         c, tx, busy, rdy);
            end
        end
        vld = '0;
        rst = 1'b1;
        @(negedge clk);
        q.push_back(8'h96);
        send_stream(0, q, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        vld = '0;
        for (int d = 0; d < 3; d++) data[d] = '0;
        test_reset;
        test_idle;
        test_single;
        test_parity;
        test_back_to_back;
        test_backpressure;
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
